// File: rtl/mux_pkg.sv
// Shared definitions for the registered N-way stream multiplexer: mode encodings and
// a constant-width helper.
package mux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Bits needed to index n items, never less than 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr, wrapping, found by rotating a
// doubled request vector and priority-encoding the lowest set bit.
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned SEL_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_any
);

  localparam int unsigned SUM_W = SEL_W + 1;

  logic [N-1:0]     req_rot;
  logic [SUM_W-1:0] idx_sum;
  logic             found;

  always_comb begin
    req_rot = N'({req, req} >> ptr);
    idx_sum = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req_rot[i]) begin
        found   = 1'b1;
        idx_sum = SUM_W'(ptr) + SUM_W'(i);
      end
    end
    // Offset from ptr can run past the last channel; fold it back without modulo 2^SEL_W.
    if (idx_sum >= SUM_W'(N)) idx_sum = idx_sum - SUM_W'(N);
    gnt_idx = SEL_W'(idx_sum);
    gnt_any = |req;
  end

endmodule

// File: rtl/mux_nway_reg.sv
// N-input registered stream multiplexer with valid/ready handshake; the channel is picked
// by an external select or by a round-robin arbiter, with one cycle of latency.
module mux_nway_reg
  import mux_pkg::*;
#(
  parameter  int unsigned WIDTH  = 16,
  parameter  int unsigned NUM_IN = 4,
  localparam int unsigned SEL_W  = clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_chan,
  input  logic                    out_ready
);

  localparam int unsigned NUM_PAD = 1 << SEL_W;

  logic [SEL_W-1:0]   rr_ptr;
  logic [SEL_W-1:0]   rr_gnt;
  logic               rr_any;
  logic [SEL_W-1:0]   grant;
  logic               gnt_vld;
  logic [NUM_PAD-1:0] valid_pad;
  logic [WIDTH-1:0]   gnt_data;
  logic               can_load;
  logic               xfer;

  rr_arbiter #(.N(NUM_IN), .SEL_W(SEL_W)) u_arb (
    .req     (in_valid),
    .ptr     (rr_ptr),
    .gnt_idx (rr_gnt),
    .gnt_any (rr_any)
  );

  // Grant source; valid is padded so an out-of-range select reads a zero.
  always_comb begin
    valid_pad = NUM_PAD'(in_valid);
    if (mode == MODE_RR) begin
      grant   = rr_gnt;
      gnt_vld = rr_any;
    end else begin
      grant   = sel;
      gnt_vld = (32'(sel) < NUM_IN) && valid_pad[sel];
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (grant == SEL_W'(i)) gnt_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign can_load = !out_valid || out_ready;
  assign xfer     = reset_n && can_load && gnt_vld;
  assign in_ready = xfer ? (NUM_IN'(1) << grant) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      rr_ptr    <= '0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= gnt_data;
        out_chan  <= grant;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (xfer && mode == MODE_RR) begin
        rr_ptr <= (32'(grant) == NUM_IN - 1) ? '0 : grant + SEL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mux_nway_reg.sv
// Bench for mux_nway_reg: a 4-input and a 3-input instance driven side by side and
// compared every cycle against a transaction-level model of the multiplexer.
module tb_mux_nway_reg;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mode = 1'b0;
  logic [1:0]  sel_a = '0, sel_b = '0;
  logic [3:0]  vld_a = '0;
  logic [2:0]  vld_b = '0;
  logic [63:0] dat_a = '0;
  logic [47:0] dat_b = '0;
  logic        ordy_a = 1'b0, ordy_b = 1'b0;
  logic [3:0]  rdy_a;
  logic [2:0]  rdy_b;
  logic        ov_a, ov_b;
  logic [15:0] od_a, od_b;
  logic [1:0]  oc_a, oc_b;

  int vectors = 0;
  int miscompares = 0;

  // Model state per instance: held beat and round-robin start position.
  bit          m_ov[2];
  logic [15:0] m_od[2];
  int          m_oc[2];
  int          m_ptr[2];

  always #5 clk = ~clk;

  mux_nway_reg #(.WIDTH(16), .NUM_IN(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .mode(mode), .sel(sel_a), .in_valid(vld_a),
    .in_data(dat_a), .in_ready(rdy_a), .out_valid(ov_a), .out_data(od_a),
    .out_chan(oc_a), .out_ready(ordy_a)
  );

  mux_nway_reg #(.WIDTH(16), .NUM_IN(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .mode(mode), .sel(sel_b), .in_valid(vld_b),
    .in_data(dat_b), .in_ready(rdy_b), .out_valid(ov_b), .out_data(od_b),
    .out_chan(oc_b), .out_ready(ordy_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_ov[u] = 1'b0; m_od[u] = '0; m_oc[u] = 0; m_ptr[u] = 0;
    end
  endtask

  // Which channel the rules pick this cycle, if any.
  function automatic void pick(input int n, input bit md, input int s, input logic [3:0] v,
                               input int ptr, output bit gv, output int g);
    int c;
    gv = 1'b0;
    g  = 0;
    if (!md) begin
      g  = s;
      gv = (s < n) && v[s];
    end else begin
      for (int k = 0; k < n; k++) begin
        c = (ptr + k) % n;
        if (!gv && v[c]) begin gv = 1'b1; g = c; end
      end
    end
  endfunction

  // Called just after a falling edge with inputs set; checks, clocks once, returns at the next falling edge.
  task automatic step();
    bit          gv, can, ordy;
    int          g, n, s;
    logic [3:0]  v, exp_rdy, got_rdy;
    logic [63:0] d;
    bit          n_ov[2];
    logic [15:0] n_od[2];
    int          n_oc[2], n_ptr[2];
    string       p;
    #1;
    for (int u = 0; u < 2; u++) begin
      n    = (u == 0) ? 4 : 3;
      v    = (u == 0) ? vld_a : {1'b0, vld_b};
      d    = (u == 0) ? dat_a : {16'h0, dat_b};
      s    = (u == 0) ? int'(sel_a) : int'(sel_b);
      ordy = (u == 0) ? ordy_a : ordy_b;
      p    = (u == 0) ? "A" : "B";
      got_rdy = (u == 0) ? rdy_a : {1'b0, rdy_b};
      can = !m_ov[u] || ordy;
      pick(n, mode, s, v, m_ptr[u], gv, g);
      exp_rdy = (reset_n && can && gv) ? (4'd1 << g) : 4'd0;
      check({p, ".in_ready"},  32'(got_rdy), 32'(exp_rdy));
      check({p, ".out_valid"}, 32'((u == 0) ? ov_a : ov_b), 32'(m_ov[u]));
      check({p, ".out_data"},  32'((u == 0) ? od_a : od_b), 32'(m_od[u]));
      check({p, ".out_chan"},  32'((u == 0) ? oc_a : oc_b), 32'(m_oc[u]));
      n_ov[u] = m_ov[u]; n_od[u] = m_od[u]; n_oc[u] = m_oc[u]; n_ptr[u] = m_ptr[u];
      if (!reset_n) begin
        n_ov[u] = 1'b0; n_od[u] = '0; n_oc[u] = 0; n_ptr[u] = 0;
      end else if (exp_rdy != 4'd0) begin
        n_ov[u] = 1'b1;
        n_od[u] = d[g*16 +: 16];
        n_oc[u] = g;
        if (mode) n_ptr[u] = (g + 1) % n;
      end else if (ordy && m_ov[u]) begin
        n_ov[u] = 1'b0;
      end
    end
    @(posedge clk);
    for (int u = 0; u < 2; u++) begin
      m_ov[u] = n_ov[u]; m_od[u] = n_od[u]; m_oc[u] = n_oc[u]; m_ptr[u] = n_ptr[u];
    end
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    reset_n = 1'b0;
    vld_a = 4'hF; vld_b = 3'h7;
    dat_a = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
    dat_b = {16'hCCCC, 16'hBBBB, 16'hAAAA};
    ordy_a = 1'b1; ordy_b = 1'b1;
    @(negedge clk);
    step();
    step();
    reset_n = 1'b1;

    // Select mode, channel 2 on both instances.
    mode = 1'b0; sel_a = 2'd2; sel_b = 2'd2;
    dat_a[32 +: 16] = 16'hBEEF;
    #1 check("sel2.in_ready", 32'(rdy_a), 32'h4);
    step();
    check("sel2.out_data", 32'(od_a), 32'hBEEF);
    check("sel2.out_chan", 32'(oc_a), 32'd2);
    dat_a[32 +: 16] = 16'hF00D;
    step();
    check("sel2.next_beat", 32'(od_a), 32'hF00D);

    // Round robin, all valid: A walks 0,1,2,3,0 and B wraps after channel 2.
    mode = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("rr.all.A", 32'(oc_a), 32'(k % 4));
      check("rr.all.B", 32'(oc_b), 32'(k % 3));
    end
    vld_a = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      step();
      check("rr.1010", 32'(oc_a), (k % 2 == 0) ? 32'd1 : 32'd3);
    end

    // Backpressure, then simultaneous drain and load.
    vld_a = 4'hF;
    ordy_a = 1'b0; ordy_b = 1'b0;
    for (int k = 0; k < 4; k++) step();
    ordy_a = 1'b1; ordy_b = 1'b1;
    step();
    step();

    // Out-of-range select on the 3-input instance.
    mode = 1'b0; sel_b = 2'd3;
    #1 check("B.sel3.in_ready", 32'(rdy_b), 32'd0);
    step();
    step();

    // Asynchronous reset while a beat is held under backpressure.
    mode = 1'b1; ordy_a = 1'b0; ordy_b = 1'b0;
    step();
    step();
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    check("rst.async.out_valid", 32'(ov_a), 32'd0);
    check("rst.async.in_ready", 32'(rdy_a), 32'd0);
    step();
    reset_n = 1'b1; ordy_a = 1'b1; ordy_b = 1'b1;
    step();
    check("rst.ptr0.A", 32'(oc_a), 32'd0);
    check("rst.ptr0.B", 32'(oc_b), 32'd0);

    // Randomised traffic.
    for (int k = 0; k < 400; k++) begin
      mode   = 1'($urandom_range(0, 1));
      sel_a  = 2'($urandom);
      sel_b  = 2'($urandom);
      vld_a  = 4'($urandom);
      vld_b  = 3'($urandom);
      dat_a  = {$urandom, $urandom};
      dat_b  = 48'({$urandom, $urandom});
      ordy_a = ($urandom_range(0, 3) != 0);
      ordy_b = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
